// File: rtl/arm_control_unit.sv
// arm_control_unit: single-cycle ARM control unit with condition gating and NZCV register.
//   Optional macro CTRL_PERF_CNT_EN enables InstrCnt/SkipCnt performance counters.
//   clk        in  clock; flags/counters update on rising edge
//   reset      in  asynchronous active-low reset
//   Instr      in  [31:0] current instruction
//   ALUFlags   in  [3:0] {N,Z,C,V} from the ALU, same cycle
//   RegSrc     out [1:0] [0]=RA1 is R15, [1]=RA2 is Instr[15:12]
//   RegWrite   out condition-gated register write enable
//   ImmSrc     out [1:0] immediate format
//   ALUSrc     out SrcB from ExtImm
//   ALUControl out [1:0] ADD/SUB/AND/ORR
//   MemtoReg   out result from ReadData
//   MemWrite   out condition-gated memory write enable
//   PCSrc      out condition-gated PC load
//   Flags      out [3:0] architectural NZCV
//   InstrCnt   out [CNT_W-1:0] executed-slot count
//   SkipCnt    out [CNT_W-1:0] condition-failed count
module arm_control_unit #(
  parameter int         CNT_W     = 32,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Instr,
  input  logic [3:0]       ALUFlags,
  output logic [1:0]       RegSrc,
  output logic             RegWrite,
  output logic [1:0]       ImmSrc,
  output logic             ALUSrc,
  output logic [1:0]       ALUControl,
  output logic             MemtoReg,
  output logic             MemWrite,
  output logic             PCSrc,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] InstrCnt,
  output logic [CNT_W-1:0] SkipCnt
);
  logic [3:0] cond, cmd, rd, flags_q, flags_d;
  logic [1:0] op, flag_w;
  logic [5:0] funct;
  logic       reg_w, mem_w, branch, no_write, cond_ex, pcs, n, z, c, v;
  logic       unused_bits;
  assign cond  = Instr[31:28];
  assign op    = Instr[27:26];
  assign funct = Instr[25:20];
  assign rd    = Instr[15:12];
  assign cmd   = funct[4:1];
  assign unused_bits = ^{Instr[19:16], Instr[11:0]};
  // Main decode; a case with a zero default keeps an unknown Op from writing memory.
  always_comb begin
    reg_w    = 1'b0;
    mem_w    = 1'b0;
    branch   = 1'b0;
    RegSrc   = 2'b00;
    ImmSrc   = 2'b00;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    case (op)
      2'b00: begin
        reg_w  = 1'b1;
        ALUSrc = funct[5];
      end
      2'b01: begin
        ImmSrc   = 2'b01;
        ALUSrc   = 1'b1;
        MemtoReg = funct[0];
        reg_w    = funct[0];
        mem_w    = ~funct[0];
        RegSrc   = funct[0] ? 2'b00 : 2'b10;
      end
      2'b10: begin
        RegSrc = 2'b01;
        ImmSrc = 2'b10;
        ALUSrc = 1'b1;
        branch = 1'b1;
      end
      default: ;
    endcase
    ALUControl = 2'b00;
    no_write   = 1'b0;
    flag_w     = 2'b00;
    if (op == 2'b00) begin
      case (cmd)
        4'b0100: ALUControl = 2'b00;
        4'b0010: ALUControl = 2'b01;
        4'b0000: ALUControl = 2'b10;
        4'b1100: ALUControl = 2'b11;
        4'b1010: begin
          ALUControl = 2'b01;
          no_write   = 1'b1;
        end
        default: reg_w = 1'b0;
      endcase
      flag_w = (cmd == 4'b1010) ? 2'b11 :
               {funct[0], funct[0] & (cmd == 4'b0100 || cmd == 4'b0010)};
    end
  end
  assign {n, z, c, v} = flags_q;
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = n == v;
      4'b1011: cond_ex = n != v;
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end
  assign pcs      = ((rd == 4'hF) & reg_w) | branch;
  assign RegWrite = reg_w & ~no_write & cond_ex;
  assign MemWrite = mem_w & cond_ex;
  assign PCSrc    = pcs & cond_ex;
  assign flags_d  = {(flag_w[1] & cond_ex) ? ALUFlags[3:2] : flags_q[3:2],
                     (flag_w[0] & cond_ex) ? ALUFlags[1:0] : flags_q[1:0]};
  always_ff @(posedge clk or negedge reset)
    if (!reset) flags_q <= FLAGS_RST;
    else flags_q <= flags_d;
  assign Flags = flags_q;
`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] instr_cnt_q, skip_cnt_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      instr_cnt_q <= '0;
      skip_cnt_q  <= '0;
    end else begin
      instr_cnt_q <= instr_cnt_q + 1'b1;
      skip_cnt_q  <= skip_cnt_q + CNT_W'(!cond_ex);
    end
  assign InstrCnt = instr_cnt_q;
  assign SkipCnt  = skip_cnt_q;
`else
  assign InstrCnt = '0;
  assign SkipCnt  = '0;
`endif
endmodule
